// File: rtl/piano_pkg.sv
// Shared types and encodings for the piano player: FSM states, mode and note codes,
// and the note-length table.
package piano_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAY,
        S_KEYWAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_END  = 4'd15;

    // Length code -> number of duration ticks.
    function automatic logic [7:0] len_ticks(input logic [1:0] code);
        case (code)
            2'd0:    len_ticks = 8'd1;
            2'd1:    len_ticks = 8'd2;
            2'd2:    len_ticks = 8'd4;
            default: len_ticks = 8'd8;
        endcase
    endfunction

    // One-hot key for notes do..si; rests and out-of-range codes give no hint.
    function automatic logic [6:0] key_hint(input logic [3:0] note);
        if (note >= 4'd1 && note <= 4'd7) key_hint = 7'(7'b1 << (note - 4'd1));
        else                              key_hint = '0;
    endfunction

    function automatic logic [3:0] lowest_key(input logic [6:0] k);
        lowest_key = NOTE_REST;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) lowest_key = 4'(i + 1);
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Duration tick divider: one-cycle tick every DIV clocks, restartable with clr so the
// first tick after a restart is a full period.
module tick_gen #(
    parameter int DIV = 6250000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;

    assign tick = (cnt_q == W'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             cnt_q <= '0;
        else if (clr || tick)   cnt_q <= '0;
        else                    cnt_q <= cnt_q + W'(1);
    end

endmodule

// File: rtl/play_sequencer.sv
// Piano song player: free play from the keys, auto playback and key-guided learn mode
// from an external synchronous song ROM.
module play_sequencer
    import piano_pkg::*;
#(
    parameter int TICK_DIV  = 6250000,
    parameter int GAP_TICKS = 1,
    parameter int SONG_CNT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic       start,
    input  logic       song_next,
    input  logic       song_prev,
    input  logic [6:0] keys,
    input  logic [1:0] octave_sw,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [3:0] note_out,
    output logic [1:0] octave_out,
    output logic [6:0] led_hint,
    output logic [3:0] song_num,
    output logic       busy,
    output logic       done
);
    state_t     state_q, state_d;
    logic [5:0] idx_q, idx_d;
    logic [1:0] song_q, song_d;
    logic [2:0] mode_q;
    logic [3:0] note_q, note_d;
    logic [1:0] oct_q, oct_d;
    logic [1:0] len_q, len_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       match_q, match;
    logic       auto_lrn, abort, tick, clr;
    logic [3:0] note_out_q, note_out_d;
    logic [1:0] oct_out_q, oct_out_d;
    logic [6:0] led_q, led_d;
    logic [7:0] rom_addr_q, rom_addr_d;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    assign auto_lrn = (mode == MODE_AUTO) || (mode == MODE_LEARN);
    assign match    = (keys == key_hint(note_q));
    // Any user action other than waiting ends the current song without a done pulse.
    assign abort    = (state_q != S_IDLE) &&
                      (!auto_lrn || (mode != mode_q) || start || (song_next ^ song_prev));

    always_comb begin
        song_d = song_q;
        if (song_next && !song_prev)
            song_d = (song_q == 2'(SONG_CNT - 1)) ? 2'd0 : song_q + 2'd1;
        else if (song_prev && !song_next)
            song_d = (song_q == 2'd0) ? 2'(SONG_CNT - 1) : song_q - 2'd1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        oct_d   = oct_q;
        len_d   = len_q;
        tcnt_d  = tcnt_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: if (auto_lrn && start) begin
                state_d = S_FETCH;
                idx_d   = '0;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                note_d = rom_data[3:0];
                oct_d  = rom_data[5:4];
                len_d  = rom_data[7:6];
                if (rom_data[3:0] == NOTE_END)
                    state_d = S_DONE;
                else if (mode == MODE_AUTO || rom_data[3:0] == NOTE_REST)
                    state_d = S_PLAY;
                else
                    state_d = S_KEYWAIT;
            end
            S_KEYWAIT: if (match && !match_q) state_d = S_PLAY;
            S_PLAY: if (tick) begin
                if (tcnt_q + 8'd1 >= len_ticks(len_q)) state_d = S_GAP;
                else                                   tcnt_d  = tcnt_q + 8'd1;
            end
            S_GAP: if (tick) begin
                if (tcnt_q + 8'd1 >= 8'(GAP_TICKS)) begin
                    // Stop at the last slot so a song without an end marker cannot wrap.
                    if (idx_q == 6'd63) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                        idx_d   = idx_q + 6'd1;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
        clr = (state_d != state_q) && (state_d == S_PLAY || state_d == S_GAP);
        if (clr) tcnt_d = '0;
    end

    always_comb begin
        note_out_d = '0;
        oct_out_d  = '0;
        led_d      = '0;
        rom_addr_d = rom_addr_q;
        if (mode == MODE_FREE) begin
            note_out_d = lowest_key(keys);
            oct_out_d  = octave_sw;
        end else begin
            if (state_d == S_PLAY)    note_out_d = note_d;
            if (state_d != S_IDLE)    oct_out_d  = oct_d;
            if (state_d == S_KEYWAIT) led_d      = key_hint(note_d);
        end
        if (state_d == S_FETCH)     rom_addr_d = {song_q, idx_d};
        else if (state_d == S_IDLE) rom_addr_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            song_q     <= '0;
            mode_q     <= '0;
            note_q     <= '0;
            oct_q      <= '0;
            len_q      <= '0;
            tcnt_q     <= '0;
            match_q    <= 1'b0;
            note_out_q <= '0;
            oct_out_q  <= '0;
            led_q      <= '0;
            rom_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            song_q     <= song_d;
            mode_q     <= mode;
            note_q     <= note_d;
            oct_q      <= oct_d;
            len_q      <= len_d;
            tcnt_q     <= tcnt_d;
            match_q    <= match;
            note_out_q <= note_out_d;
            oct_out_q  <= oct_out_d;
            led_q      <= led_d;
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign note_out   = note_out_q;
    assign octave_out = oct_out_q;
    assign led_hint   = led_q;
    assign song_num   = {2'b00, song_q} + 4'd1;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);

endmodule
